keypad_matrix_emulator: RTL and testbench

- Drives the column side of a 4x4 keypad matrix in response to row-scan strobes, so a scanner under test or on a second board sees real key presses.
- Accepts one key press per valid/ready request, with a programmed hold time.
- Optionally emulates contact bounce, then enforces a release gap so the scanner's pause timeout can expire before the next press.

---
 rtl/keypad_matrix_emulator_pkg.sv | 37 +++
 rtl/keypad_matrix_emulator_key_map.sv | 34 +++
 rtl/keypad_matrix_emulator.sv | 111 +++++++++++
 tb/tb_keypad_matrix_emulator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_matrix_emulator_pkg.sv
// Shared keypad codes, geometry and emulator state encodings.
// Imported by the emulator, its key map and any scanner bench.
package keypad_matrix_emulator_pkg;

  localparam int KEYPAD_ROW_WIDTH    = 4;
  localparam int KEYPAD_COL_WIDTH    = 4;
  localparam int KEYPAD_PAUSE_PERIOD = 16;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef enum logic [1:0] {
    EMU_IDLE    = 2'd0,
    EMU_BOUNCE  = 2'd1,
    EMU_PRESS   = 2'd2,
    EMU_RELEASE = 2'd3
  } emu_state_e;

  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_key_map.sv
// Key code to active-low row/column pattern of the 4x4 matrix.
// Pure combinational; doubles as a golden model for scanner benches.
module keypad_key_map
  import keypad_matrix_emulator_pkg::*;
(
  input  logic [3:0] key,
  output logic [3:0] row_n,
  output logic [3:0] col_n
);

  always_comb begin
    row_n = 4'b1111;
    col_n = 4'b1111;
    unique case (key)
      KEY_F: {row_n, col_n} = 8'b0111_0111;
      KEY_E: {row_n, col_n} = 8'b0111_1011;
      KEY_D: {row_n, col_n} = 8'b0111_1101;
      KEY_C: {row_n, col_n} = 8'b0111_1110;
      KEY_B: {row_n, col_n} = 8'b1011_0111;
      KEY_3: {row_n, col_n} = 8'b1011_1011;
      KEY_6: {row_n, col_n} = 8'b1011_1101;
      KEY_9: {row_n, col_n} = 8'b1011_1110;
      KEY_A: {row_n, col_n} = 8'b1101_0111;
      KEY_2: {row_n, col_n} = 8'b1101_1011;
      KEY_5: {row_n, col_n} = 8'b1101_1101;
      KEY_8: {row_n, col_n} = 8'b1101_1110;
      KEY_0: {row_n, col_n} = 8'b1110_0111;
      KEY_1: {row_n, col_n} = 8'b1110_1011;
      KEY_4: {row_n, col_n} = 8'b1110_1101;
      KEY_7: {row_n, col_n} = 8'b1110_1110;
    endcase
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one key press per request on a 4x4 matrix column return,
// with optional contact bounce and an enforced release gap.
module keypad_matrix_emulator
  import keypad_matrix_emulator_pkg::*;
#(
  parameter int HOLD_W         = 8,
  parameter int BOUNCE_CYCLES  = 6,
  parameter int RELEASE_CYCLES = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row_n,
  output logic [3:0]        col_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_key,
  input  logic [HOLD_W-1:0] req_hold,
  output logic              busy,
  output logic              done
);

  localparam int PHASE_MAX =
    (BOUNCE_CYCLES > RELEASE_CYCLES) ? BOUNCE_CYCLES : RELEASE_CYCLES;
  localparam int CW = cnt_width(PHASE_MAX);
  localparam logic [CW-1:0] B_LAST =
    CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CYCLES - 1);

  emu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        key_q, key_d;
  logic              done_q, done_d;
  logic              key_on;
  logic [3:0]        map_row, map_col;

  keypad_key_map u_map (
    .key   (key_q),
    .row_n (map_row),
    .col_n (map_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMU_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    key_d   = key_q;
    done_d  = 1'b0;
    key_on  = 1'b0;
    unique case (state_q)
      EMU_IDLE: begin
        if (req_valid) begin
          key_d   = req_key;
          hold_d  = (req_hold == '0) ? HOLD_W'(1) : req_hold;
          cnt_d   = '0;
          state_d = (BOUNCE_CYCLES > 0) ? EMU_BOUNCE : EMU_PRESS;
        end
      end
      EMU_BOUNCE: begin
        key_on = cnt_q[0];
        if (cnt_q == B_LAST) begin
          cnt_d   = '0;
          state_d = EMU_PRESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMU_PRESS: begin
        key_on = 1'b1;
        if (hold_q == HOLD_W'(1)) begin
          cnt_d   = '0;
          state_d = EMU_RELEASE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      EMU_RELEASE: begin
        if (cnt_q == R_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = EMU_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Non-one-hot strobes never match a key row, so they read as released.
  assign col_n     = (key_on && row_n == map_row) ? map_col : 4'b1111;
  assign req_ready = (state_q == EMU_IDLE);
  assign busy      = !req_ready;
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Randomized self-checking bench for keypad_matrix_emulator.
// Reference model works from the key layout and phase timing.
module tb_keypad_matrix_emulator;

  localparam int HW = 8;
  localparam int B  = 6;
  localparam int R  = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    row_n = 4'b1111;
  logic [3:0]    col_n;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_key = 4'h0;
  logic [HW-1:0] req_hold = '0;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  keypad_matrix_emulator #(
    .HOLD_W         (HW),
    .BOUNCE_CYCLES  (B),
    .RELEASE_CYCLES (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_hold  (req_hold),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Physical layout: row r strobe is ~(1000>>r), column c return ~(1000>>c).
  logic [3:0] layout [4][4] = '{
    '{4'hF, 4'hE, 4'hD, 4'hC},
    '{4'hB, 4'h3, 4'h6, 4'h9},
    '{4'hA, 4'h2, 4'h5, 4'h8},
    '{4'h0, 4'h1, 4'h4, 4'h7}
  };

  function automatic logic [3:0] model_col(logic [3:0] k, logic [3:0] row,
                                           bit on);
    logic [3:0] res;
    res = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (on && layout[r][c] == k && row == ~(4'b1000 >> r))
          res = ~(4'b1000 >> c);
    return res;
  endfunction

  // Offset d counts cycles after the accept edge (d = 1 is first busy cycle).
  function automatic bit model_on(int d, int h);
    if (d <= B) return ((d - 1) % 2) == 1;
    return d <= B + h;
  endfunction

  function automatic logic [3:0] rand_row();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel < 4) return ~(4'b1000 >> sel);
    return 4'($urandom);
  endfunction

  task automatic test_reset();
    logic [3:0] rows [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      row_n = rows[i];
      #1;
      checks++;
      if (col_n !== 4'b1111 || req_ready !== 1'b1 || busy !== 1'b0 ||
          done !== 1'b0) begin
        errors++;
        $display("FAIL reset row=%b col=%b ready=%b busy=%b done=%b want 1111/1/0/0",
                 row_n, col_n, req_ready, busy, done);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_rows();
    logic [3:0] rows [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      row_n = rows[i % 4];
      #1;
      checks++;
      if (col_n !== 4'b1111 || req_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle row=%b col=%b ready=%b busy=%b want 1111/1/0",
                 row_n, col_n, req_ready, busy);
      end
    end
  endtask

  // One press, checked cycle by cycle against the model through IDLE return.
  task automatic run_press(input logic [3:0] k, input int hold,
                           input bit fixed, input logic [3:0] frow,
                           input bit spam, input bit chained,
                           input bit chain_next, input logic [3:0] nk,
                           input int nhold);
    int h, total, hits, want_hits;
    logic [3:0] ec;
    h = (hold == 0) ? 1 : hold;
    total = B + h + R;
    hits = 0;
    want_hits = 0;
    if (!chained) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_key   = k;
      req_hold  = HW'(hold);
      row_n     = fixed ? frow : rand_row();
      #1;
      checks++;
      if (req_ready !== 1'b1 || col_n !== 4'b1111) begin
        errors++;
        $display("FAIL accept_idle key=%h ready=%b col=%b want 1/1111",
                 k, req_ready, col_n);
      end
    end
    @(posedge clk);
    #1;
    req_valid = spam;
    req_key   = 4'h7;
    req_hold  = HW'($urandom_range(0, 50));
    for (int d = 1; d <= total + 1; d++) begin
      @(negedge clk);
      row_n = fixed ? frow : rand_row();
      if (d == total + 1) begin
        req_valid = chain_next;
        req_key   = nk;
        req_hold  = HW'(nhold);
      end
      #1;
      ec = model_col(k, row_n, model_on(d, h));
      if (ec != 4'b1111) want_hits++;
      if (col_n != 4'b1111) hits++;
      checks++;
      if (col_n !== ec || busy !== (d <= total) ||
          req_ready !== (d > total) || done !== (d == total + 1)) begin
        errors++;
        $display("FAIL press key=%h d=%0d row=%b col=%b busy=%b ready=%b done=%b want col=%b busy=%b done=%b",
                 k, d, row_n, col_n, busy, req_ready, done, ec,
                 d <= total, d == total + 1);
      end
    end
    checks++;
    if (hits !== want_hits) begin
      errors++;
      $display("FAIL press_hits key=%h got=%0d want=%0d", k, hits, want_hits);
    end
  endtask

  task automatic test_press_basic();
    run_press(4'h5, 10, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    run_press(4'hF, 0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    run_press(4'hF, 0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 4'h0, 0);
  endtask

  task automatic test_bounce();
    run_press(4'h1, 8, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 4'h0, 0);
  endtask

  task automatic test_busy_ignored();
    run_press(4'h2, 12, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'h0, 0);
    run_press(4'h7, 5, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 4'h0, 0);
  endtask

  task automatic test_back_to_back();
    run_press(4'hA, 3, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 4'hC, 2);
    run_press(4'hC, 2, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 4'h0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_press(4'($urandom), $urandom_range(0, 20), 1'b0, 4'b1111,
                1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'h0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1;
    req_key   = 4'h9;
    req_hold  = HW'(20);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < B + 3; i++) @(negedge clk);
    row_n = 4'b1011;
    #1;
    checks++;
    if (col_n !== 4'b1110) begin
      errors++;
      $display("FAIL mid_press col=%b want 1110", col_n);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (col_n !== 4'b1111 || req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset col=%b ready=%b done=%b want 1111/1/0",
               col_n, req_ready, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      row_n = rand_row();
      #1;
      checks++;
      if (done !== 1'b0 || col_n !== 4'b1111 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset i=%0d done=%b col=%b busy=%b want 0/1111/0",
                 i, done, col_n, busy);
      end
    end
  endtask

  // Scanner-style loop: sweep rows and decode the pressed key from col_n.
  task automatic test_scan_loop();
    int seen_press, seen_other, idle_after;
    logic [3:0] found;
    seen_press = 0;
    seen_other = 0;
    idle_after = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_key   = 4'h3;
    req_hold  = HW'(40);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int cyc = 0; cyc < B + 40 + R + 20; cyc++) begin
      @(negedge clk);
      row_n = ~(4'b1000 >> (cyc % 4));
      #1;
      if (col_n != 4'b1111) begin
        found = 4'hx;
        for (int c = 0; c < 4; c++)
          if (col_n == ~(4'b1000 >> c)) found = layout[cyc % 4][c];
        if (found === 4'h3) seen_press++;
        else seen_other++;
      end
      if (cyc > B + 40 + R && col_n == 4'b1111 && !busy) idle_after++;
    end
    checks++;
    if (seen_press < 10 || seen_other !== 0 || idle_after < 15) begin
      errors++;
      $display("FAIL scan_loop key3 hits=%0d other=%0d idle_after=%0d want >=10/0/>=15",
               seen_press, seen_other, idle_after);
    end
  endtask

  initial begin
    test_reset();
    test_idle_rows();
    test_press_basic();
    test_bounce();
    test_busy_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_scan_loop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
